bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that turns an unsigned binary value into four packed BCD digits. It sits directly upstream of the 4-digit multiplexed 7-segment driver and feeds that driver's 16-bit digit input. Values above 9999 saturate to 9999 with an overflow flag, so the display always shows decimal. The result register holds the last conversion, giving the display a stable value between updates.

---
 rtl/bin2bcd_seq.sv | 114 +++++++++++
 tb/tb_bin2bcd_seq.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to 4-digit packed BCD converter.
// Saturates to 9999 with ovf; result register holds between conversions.
module bin2bcd_seq #(
    parameter int IN_W = 14
) (
    input  logic            sys_clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IN_W-1:0] bin,
    output logic [15:0]     bcd,
    output logic            busy,
    output logic            done,
    output logic            ovf
);

    localparam int CW = $clog2(IN_W + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(IN_W);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [15:0] SAT_BCD = 16'h9999;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t state_q, state_d;

    logic [IN_W-1:0]    shift_q, shift_d;
    logic [15:0]        scr_q, scr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [15:0]        bcd_d;
    logic               busy_d, done_d, ovf_d;
    logic [15:0]        scr_adj;
    logic [IN_W+15:0]   shifted;
    logic               in_sat;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    assign in_sat = (32'(bin) > 32'd9999);

    // One double-dabble iteration: correct digits, then shift in next bit.
    always_comb begin
        scr_adj = '0;
        for (int i = 0; i < 4; i++) begin
            scr_adj[i*4 +: 4] = add3(scr_q[i*4 +: 4]);
        end
        shifted = {scr_adj, shift_q} << 1;
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        bcd_d   = bcd;
        ovf_d   = ovf;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = bin;
                    scr_d   = '0;
                    cnt_d   = CNT_INIT;
                    sat_d   = in_sat;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                busy_d = 1'b1;
                {scr_d, shift_d} = shifted;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ovf_d   = sat_q;
                    bcd_d   = sat_q ? SAT_BCD : shifted[IN_W+15:IN_W];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            bcd     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            bcd     <= bcd_d;
            busy    <= busy_d;
            done    <= done_d;
            ovf     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a decimal reference model.
// Covers reset, boundaries, busy rejection, back-to-back and random sweep.
module tb_bin2bcd_seq;

    localparam int IN_W = 14;

    logic            sys_clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [IN_W-1:0] bin = '0;
    logic [15:0]     bcd;
    logic            busy;
    logic            done;
    logic            ovf;

    int n_cmp = 0;
    int n_fail = 0;

    bin2bcd_seq #(.IN_W(IN_W)) dut (
        .sys_clk(sys_clk),
        .reset  (reset),
        .start  (start),
        .bin    (bin),
        .bcd    (bcd),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    // Launch one conversion from idle and wait (bounded) for done.
    task automatic run_conv(input int v, output logic [15:0] r,
                            output logic o, output int lat,
                            output int busy_n, output logic busy_at_done,
                            output bit to);
        r = '0;
        o = 1'b0;
        lat = 0;
        busy_n = 0;
        busy_at_done = 1'b1;
        to = 1'b1;
        start = 1'b1;
        bin = IN_W'(v);
        step();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                to = 1'b0;
                r = bcd;
                o = ovf;
                busy_at_done = busy;
                break;
            end
            if (busy) busy_n++;
            lat++;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        bin = '0;
        repeat (3) step();
        n_cmp++;
        if ({bcd, busy, done, ovf} !== 19'b0) begin
            n_fail++;
            $display("FAIL reset_init got bcd=%h busy=%b done=%b ovf=%b exp all 0",
                     bcd, busy, done, ovf);
        end
        reset = 1'b1;
        step();
        start = 1'b1;
        bin = IN_W'(1234);
        step();
        start = 1'b0;
        repeat (4) step();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bcd, busy, done} !== 18'b0) begin
            n_fail++;
            $display("FAIL reset_async got bcd=%h busy=%b done=%b exp 0", bcd, busy, done);
        end
        step();
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            n_cmp++;
            if ({bcd, busy, done, ovf} !== 19'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d got bcd=%h busy=%b done=%b ovf=%b exp all 0",
                         i, bcd, busy, done, ovf);
            end
        end
    endtask

    task automatic test_single();
        logic [15:0] r;
        logic o, bd;
        int lat, bn;
        bit to;
        run_conv(1234, r, o, lat, bn, bd, to);
        n_cmp++;
        if (to) begin
            n_fail++;
            $display("FAIL single_timeout got no done exp done");
        end
        n_cmp++;
        if (r !== 16'h1234) begin
            n_fail++;
            $display("FAIL single_bcd got %h exp 1234", r);
        end
        n_cmp++;
        if (o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ovf got %b exp 0", o);
        end
        n_cmp++;
        if (lat !== IN_W) begin
            n_fail++;
            $display("FAIL single_latency got %0d exp %0d", lat, IN_W);
        end
        n_cmp++;
        if (bn !== IN_W || bd !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy got cycles=%0d at_done=%b exp %0d 0", bn, bd, IN_W);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (done !== 1'b0 || bcd !== 16'h1234 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL single_hold cyc %0d got done=%b bcd=%h busy=%b exp 0 1234 0",
                         i, done, bcd, busy);
            end
        end
    endtask

    task automatic test_boundaries();
        int vals[7] = '{0, 9, 10, 9999, 10000, 16383, 5};
        logic [15:0] r;
        logic o, bd;
        int lat, bn;
        bit to;
        foreach (vals[i]) begin
            run_conv(vals[i], r, o, lat, bn, bd, to);
            n_cmp++;
            if (to || r !== ref_bcd(vals[i]) || o !== (vals[i] > 9999)) begin
                n_fail++;
                $display("FAIL boundary bin=%0d got bcd=%h ovf=%b to=%b exp %h %b",
                         vals[i], r, o, to, ref_bcd(vals[i]), vals[i] > 9999);
            end
            step();
        end
    endtask

    task automatic test_busy_reject();
        int nd;
        logic [15:0] got;
        nd = 0;
        got = '0;
        bin = IN_W'(4321);
        start = 1'b1;
        step();
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin
                start = 1'b1;
                bin = IN_W'(7777);
            end else begin
                start = 1'b0;
                bin = IN_W'($urandom);
            end
            step();
            if (done) begin
                nd++;
                got = bcd;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (nd !== 1) begin
            n_fail++;
            $display("FAIL busy_reject_dones got %0d exp 1", nd);
        end
        n_cmp++;
        if (got !== 16'h4321) begin
            n_fail++;
            $display("FAIL busy_reject_bcd got %h exp 4321", got);
        end
    endtask

    task automatic test_back_to_back();
        int seq[3] = '{100, 2048, 9090};
        int tm[3] = '{-1, -1, -1};
        logic [15:0] v[3] = '{16'h0, 16'h0, 16'h0};
        int nd;
        nd = 0;
        bin = IN_W'(seq[0]);
        start = 1'b1;
        step();
        for (int t = 0; t < 80; t++) begin
            if (done) begin
                v[nd] = bcd;
                tm[nd] = t;
                nd++;
                if (nd < 3) bin = IN_W'(seq[nd]);
                else start = 1'b0;
            end
            if (nd == 3) break;
            step();
        end
        start = 1'b0;
        n_cmp++;
        if (nd !== 3) begin
            n_fail++;
            $display("FAIL b2b_count got %0d exp 3", nd);
        end
        n_cmp++;
        if (tm[0] !== IN_W || tm[1] - tm[0] !== IN_W + 1 || tm[2] - tm[1] !== IN_W + 1) begin
            n_fail++;
            $display("FAIL b2b_timing got %0d %0d %0d exp %0d %0d %0d",
                     tm[0], tm[1], tm[2], IN_W, 2 * IN_W + 1, 3 * IN_W + 2);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (v[i] !== ref_bcd(seq[i])) begin
                n_fail++;
                $display("FAIL b2b_bcd idx %0d got %h exp %h", i, v[i], ref_bcd(seq[i]));
            end
        end
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] r;
        logic o, bd;
        int lat, bn, nd;
        bit to;
        bin = IN_W'(5678);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bcd, busy, done, ovf} !== 19'b0) begin
            n_fail++;
            $display("FAIL reset_mid_abort got bcd=%h busy=%b done=%b ovf=%b exp all 0",
                     bcd, busy, done, ovf);
        end
        step();
        step();
        reset = 1'b1;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done || busy) nd++;
        end
        n_cmp++;
        if (nd !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet got %0d active cycles exp 0", nd);
        end
        run_conv(42, r, o, lat, bn, bd, to);
        n_cmp++;
        if (to || r !== 16'h0042 || lat !== IN_W) begin
            n_fail++;
            $display("FAIL reset_mid_after got bcd=%h lat=%0d to=%b exp 0042 %0d 0",
                     r, lat, to, IN_W);
        end
        step();
    endtask

    task automatic test_random();
        logic [15:0] r;
        logic o, bd;
        int lat, bn, v;
        bit to;
        for (int i = 0; i < 2000; i++) begin
            v = int'($urandom_range(0, (1 << IN_W) - 1));
            run_conv(v, r, o, lat, bn, bd, to);
            n_cmp++;
            if (to || r !== ref_bcd(v) || o !== (v > 9999) || lat !== IN_W) begin
                n_fail++;
                $display("FAIL random bin=%0d got bcd=%h ovf=%b lat=%0d to=%b exp %h %b %0d",
                         v, r, o, lat, to, ref_bcd(v), v > 9999, IN_W);
            end
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundaries();
        test_busy_reject();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
